// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-port arbiter in front of a single unified memory. Port 0 (CPU) and
//   port 1 (loader/debug) compete round-robin; a port may lock the memory
//   for consecutive accesses. Reads return one cycle after the grant.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req0/req1            access request, held until granted
//   we0/we1              1 = write, 0 = read
//   lock0/lock1          keep exclusive ownership after the current grant
//   addr0/addr1          access address (ADDR_W)
//   wdata0/wdata1        write data (DATA_W)
//   gnt0/gnt1            combinational grant; access happens this cycle
//   rvalid0/rvalid1      one-cycle read-return strobe per port
//   rdata                registered read data
//   mem_we/mem_addr/mem_wd  memory command driven from the granted port
//   mem_rd               combinational memory read data
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last1;     // 1: port 1 was granted most recently
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_gnt0;
    logic                w_gnt1;

    // Next-state and grant decode. Reset masks grants so nothing reaches
    // the memory while the block is being reset.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req0 && req1) begin
                        w_gnt0 = r_last1;
                        w_gnt1 = !r_last1;
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                    if (w_gnt0 && lock0)
                        w_state_nxt = ST_OWN0;
                    else if (w_gnt1 && lock1)
                        w_state_nxt = ST_OWN1;
                end
                ST_OWN0: begin
                    // Owner keeps its grant in the release cycle too.
                    w_gnt0 = req0;
                    if (!lock0)
                        w_state_nxt = ST_IDLE;
                end
                ST_OWN1: begin
                    w_gnt1 = req1;
                    if (!lock1)
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last1   <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            if (w_gnt0)
                r_last1 <= 1'b0;
            else if (w_gnt1)
                r_last1 <= 1'b1;
            r_rvalid0 <= w_gnt0 && !we0;
            r_rvalid1 <= w_gnt1 && !we1;
            if ((w_gnt0 && !we0) || (w_gnt1 && !we1))
                r_rdata <= mem_rd;
        end
    end

    // Port 0 is the default source so the memory address is stable when idle.
    always_comb begin
        mem_addr = w_gnt1 ? addr1  : addr0;
        mem_wd   = w_gnt1 ? wdata1 : wdata0;
        mem_we   = (w_gnt0 && we0) || (w_gnt1 && we1);
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Bench-side memory: read data is a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    assign mem_rd = memf(mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the memory (-1 none), who was served last,
    // and what read return is due next cycle.
    int          m_owner = -1;
    int          m_last  = 1;
    bit          m_valid = 0;
    bit          m_rv0 = 0, m_rv1 = 0;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin : compare
        int          win;
        logic [31:0] e_addr;
        bit          e_we;
        win = -1;
        if (!rst) begin
            if (m_owner == 0)      win = req0 ? 0 : -1;
            else if (m_owner == 1) win = req1 ? 1 : -1;
            else if (req0 && req1) win = (m_last == 1) ? 0 : 1;
            else if (req0)         win = 0;
            else if (req1)         win = 1;
        end
        e_addr = (win == 1) ? addr1 : addr0;
        e_we   = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
        if (m_valid) begin
            chk("gnt0", gnt0, win == 0);
            chk("gnt1", gnt1, win == 1);
            chk("one_grant", gnt0 && gnt1, 0);
            chk("gnt_needs_req", (gnt0 && !req0) || (gnt1 && !req1), 0);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wd", mem_wd, (win == 1) ? wdata1 : wdata0);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            chk("rdata", rdata, m_rdata);
        end
        if (rst) begin
            m_valid = 1; m_owner = -1; m_last = 1;
            m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
        end else if (m_valid) begin
            m_rv0 = (win == 0) && !e_we;
            m_rv1 = (win == 1) && !e_we;
            if (m_rv0 || m_rv1) m_rdata = memf(e_addr);
            if (win >= 0) m_last = win;
            if (m_owner == -1) begin
                if ((win == 0 && lock0) || (win == 1 && lock1)) m_owner = win;
            end else if ((m_owner == 0 && !lock0) || (m_owner == 1 && !lock1)) begin
                m_owner = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic idle_in();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        idle_in();
        rst = 1; req0 = 1; req1 = 1; we0 = 1;
        #4;
        chk("rst_no_gnt0", gnt0, 0);
        chk("rst_no_gnt1", gnt1, 0);
        chk("rst_no_we", mem_we, 0);
        tick(); tick();
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata", rdata, 0);

        // Round-robin alternation of reads.
        rst = 0; idle_in();
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
        for (int i = 0; i < 4; i++) begin
            probe();
            chk("rr_gnt0", gnt0, (i % 2) == 0);
            chk("rr_gnt1", gnt1, (i % 2) == 1);
            if (i > 0) begin
                chk("rr_rvalid0", rvalid0, (i % 2) == 1);
                chk("rr_rvalid1", rvalid1, (i % 2) == 0);
                chk("rr_rdata", rdata, (i % 2) ? 32'h5A4A0010 : 32'h5A7A0020);
            end
            tick();
        end
        idle_in();
        probe();
        chk("rr_last_rvalid1", rvalid1, 1);
        chk("rr_last_rdata", rdata, 32'h5A7A0020);
        tick();

        // Lone write on port 1.
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hDEADBEEF;
        probe();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h40);
        chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
        tick();
        idle_in();
        probe();
        chk("wr_no_rvalid", rvalid0 || rvalid1, 0);
        chk("wr_rdata_held", rdata, 32'h5A7A0020);
        tick();

        // Port 1 locks for three reads while port 0 waits.
        req0 = 1; addr0 = 32'h10;
        tick();
        req1 = 1; lock1 = 1; addr1 = 32'h30;
        probe();
        chk("lk_gnt1_first", gnt1, 1);
        tick();
        addr1 = 32'h34;
        probe();
        chk("lk_gnt0_wait_a", gnt0, 0);
        chk("lk_gnt1_b", gnt1, 1);
        chk("lk_rdata_30", rdata, 32'h5A6A0030);
        tick();
        addr1 = 32'h38; lock1 = 0;
        probe();
        chk("lk_gnt0_wait_b", gnt0, 0);
        chk("lk_gnt1_release", gnt1, 1);
        tick();
        req1 = 0;
        probe();
        chk("lk_gnt0_after", gnt0, 1);
        chk("lk_rdata_38", rdata, 32'h5A620038);
        tick();

        // Port 0 locks, idles under lock, then reset mid-ownership.
        idle_in();
        req0 = 1; lock0 = 1; addr0 = 32'h50;
        tick();
        req0 = 0; req1 = 1;
        probe();
        chk("own0_idle_gnt0", gnt0, 0);
        chk("own0_idle_gnt1", gnt1, 0);
        tick();
        req0 = 1; addr0 = 32'h54;
        probe();
        chk("own0_gnt0", gnt0, 1);
        tick();
        rst = 1;
        probe();
        chk("own0_rst_gnt", gnt0 || gnt1, 0);
        tick();
        rst = 0; lock0 = 0;
        probe();
        chk("post_rst_rvalid0", rvalid0, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_gnt0", gnt0, 1);
        chk("post_rst_gnt1", gnt1, 0);
        tick();

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 10000; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            req0   = $urandom_range(0, 1);
            req1   = $urandom_range(0, 1);
            we0    = $urandom_range(0, 2) == 0;
            we1    = $urandom_range(0, 2) == 0;
            lock0  = $urandom_range(0, 2) == 0;
            lock1  = $urandom_range(0, 2) == 0;
            addr0  = $urandom;
            addr1  = $urandom;
            wdata0 = $urandom;
            wdata1 = $urandom;
            tick();
        end
        idle_in();
        rst = 0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
